pc_seq_unit: RTL
================

Name: pc_seq_unit

Overview:
Parametrised program-counter unit, successor to the single-width PC block.
- Holds the PC and selects the next PC from the eight existing source buses plus a new return-address-stack (RAS) pop source.
- Contains a hardware RAS for call/return with depth and overflow/underflow tracking.
- Sits between control (pcSrc, pcWrite, call) and instruction fetch (pcCur).

Parameters:
- WIDTH, 16: PC and source bus width in bits.
- INC, 2: sequential increment added for pcSrc=0 and for the call return address.
- RAS_DEPTH, 4: number of RAS entries; power of two, minimum 2.
- RESET_VEC, 0: PC value on reset.

Ports:
- clock  in  1  system clock, rising-edge active
- reset_n  in  1  asynchronous active-low reset
- pcWrite  in  1  PC and RAS update enable
- pcSrc  in  4  next-PC select
- call  in  1  push return address this cycle (qualified by pcWrite)
- immPlusPC  in  WIDTH  source 1
- immAddr  in  WIDTH  source 2
- ra  in  WIDTH  source 3; also the underflow fallback
- mary  in  WIDTH  source 4
- pcPlusMary  in  WIDTH  source 5
- jcmpImm  in  WIDTH  source 6
- jcmpImmLS  in  WIDTH  source 7
- pcCur  out  WIDTH  current PC, registered
- rasEmpty  out  1  RAS count == 0
- rasFull  out  1  RAS count == RAS_DEPTH
- rasOverflow  out  1  sticky: a push occurred while full
- rasUnderflow  out  1  sticky: a pop occurred while empty
- misalign  out  1  see Optional Feature

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pcCur=RESET_VEC.
  - RAS count=0, top pointer=0; entry contents are don't-care.
  - rasOverflow=0, rasUnderflow=0, misalign=0.
- All updates occur on the rising clock edge when pcWrite=1. When pcWrite=0, the PC, RAS and flags hold, regardless of call or pcSrc.
- Next-PC select:
  - 0: pcCur+INC
  - 1–7: immPlusPC, immAddr, ra, mary, pcPlusMary, jcmpImm, jcmpImmLS
  - 8: RAS pop (RET)
  - 9–15: hold pcCur; the RAS still services call.
- Arithmetic is modulo 2^WIDTH; pcCur+INC wraps silently from all-ones.
- Latency: the selected value appears on pcCur one cycle after the enabling edge.
- Push (call=1, pcWrite=1): stores pcCur+INC (wrapped).
  - Not full: count+1.
  - Full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, rasOverflow sets.
- Pop (pcSrc=8, pcWrite=1):
  - Count>0: next PC = top entry, count-1.
  - Count==0: next PC = ra, count stays 0, rasUnderflow sets.
- Simultaneous pop and push:
  - Next PC = old top.
  - The top entry is replaced with pcCur+INC; count is unchanged.
  - If count was 0: underflow handling applies (PC=ra, rasUnderflow sets), then the push is performed (count=1).
- Sticky flags clear only on reset.
- Reset mid-operation aborts any push/pop immediately; no partial update survives.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined:
  - When a loaded target (any pcSrc≠0, including a RAS pop) has nonzero bits below log2(INC), those bits are cleared before loading.
  - misalign pulses high for the one cycle after that load.
  - INC must be a power of two.
- Not defined: targets load unmodified and misalign is tied 0.

Decomposition:
- Package pc_pkg holds:
  - pcSrc encoding constants PC_SRC_INC..PC_SRC_RET (0..8)
  - the source count constant (9)
  - a WIDTH-parametrised helper function for increment-with-wrap
- Sub-module ras_stack (params WIDTH, RAS_DEPTH) owns:
  - entry storage, circular top pointer and count
  - push/pop/replace semantics
  - full/empty and the sticky flags
- The top level owns the source mux and the PC register.

Test Plan:
- Reset then hold: reset_n low 30 ns, pcWrite=0 for 5 cycles → pcCur=0, rasEmpty=1, no flags set.
- Sources: pcWrite=1, pcSrc=0 for 5 cycles from 0 → pcCur 2,4,6,8,10. Then pcSrc=1..7 with sources 1..7 → pcCur equals each source one cycle later. Then pcSrc=12 → pcCur holds.
- Call/return: pcCur=0x0010, call=1 with pcSrc=2, immAddr=0x0100 → pcCur=0x0100, RAS top=0x0012. Then pcSrc=8 → pcCur=0x0012, rasEmpty=1.
- Overflow: with RAS_DEPTH=4, 5 calls from PCs 0x10,0x20,0x30,0x40,0x50 → rasOverflow=1, rasFull=1. Then 4 returns → 0x52,0x42,0x32,0x22, rasEmpty=1.
- Underflow and combined: pop while empty with ra=0x0300 → pcCur=0x0300, rasUnderflow=1. Then pcSrc=8 with call=1 at count 1 (top 0x0044, pcCur 0x0200) → pcCur=0x0044, top=0x0202, count=1.
- Wrap and async reset:
  - WIDTH=16, pcCur=0xFFFE, pcSrc=0 → 0x0000.
  - reset_n asserted between edges → pcCur=RESET_VEC immediately.
  - With PC_ALIGN_CHECK_EN, immAddr=0x0103 → pcCur=0x0102 and misalign pulses for 1 cycle.

Source files
------------

// File: rtl/pc_seq_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding and
// the wrapping increment helper used for both sequential fetch and call return.
package pc_pkg;

    localparam logic [3:0] PC_SRC_INC     = 4'd0;
    localparam logic [3:0] PC_SRC_IMMPC   = 4'd1;
    localparam logic [3:0] PC_SRC_IMMADDR = 4'd2;
    localparam logic [3:0] PC_SRC_RA      = 4'd3;
    localparam logic [3:0] PC_SRC_MARY    = 4'd4;
    localparam logic [3:0] PC_SRC_PCMARY  = 4'd5;
    localparam logic [3:0] PC_SRC_JCMP    = 4'd6;
    localparam logic [3:0] PC_SRC_JCMPLS  = 4'd7;
    localparam logic [3:0] PC_SRC_RET     = 4'd8;

    localparam int PC_SRC_COUNT = 9;
    localparam int PC_MAX_W     = 64;

    // Widest supported PC is PC_MAX_W; callers zero-extend and cast the result back.
    function automatic logic [PC_MAX_W-1:0] pc_inc_wrap(
        input logic [PC_MAX_W-1:0] pc,
        input logic [PC_MAX_W-1:0] inc,
        input int unsigned         width
    );
        logic [PC_MAX_W-1:0] mask;
        mask = (width >= PC_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        return (pc + inc) & mask;
    endfunction

endpackage

// File: rtl/pc_seq_unit_ras_stack.sv
// Circular return-address stack: push/pop/replace, full/empty status and
// sticky overflow/underflow flags. Entry contents are not reset.
module ras_stack #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_hit,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_udf;

    logic             w_empty;
    logic             w_full;
    logic             w_replace;
    logic             w_push_new;
    logic             w_pop_only;
    logic [PTR_W-1:0] w_top_inc;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_W'(RAS_DEPTH));
    // Pop+push on a non-empty stack swaps the top in place; on an empty stack
    // the pop underflows and the push proceeds as a normal push.
    assign w_replace  = push & pop & ~w_empty;
    assign w_push_new = push & ~w_replace;
    assign w_pop_only = pop & ~push & ~w_empty;
    assign w_top_inc  = r_top + PTR_W'(1);

    always_ff @(posedge clock) begin
        if (w_replace)
            r_mem[r_top] <= push_data;
        else if (w_push_new)
            r_mem[w_top_inc] <= push_data;
    end

    // When full, top+1 is the oldest entry, so a push overwrites it naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_top <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_push_new) begin
                r_top <= w_top_inc;
                if (w_full)
                    r_ovf <= 1'b1;
                else
                    r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop_only) begin
                r_top <= r_top - PTR_W'(1);
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (pop && w_empty)
                r_udf <= 1'b1;
        end
    end

    assign pop_hit   = ~w_empty;
    assign top_data  = r_mem[r_top];
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter unit: next-PC source mux, PC register and return-address stack.
// Optional target alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               INC       = 2,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pcWrite,
    input  logic [3:0]       pcSrc,
    input  logic             call,
    input  logic [WIDTH-1:0] immPlusPC,
    input  logic [WIDTH-1:0] immAddr,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] mary,
    input  logic [WIDTH-1:0] pcPlusMary,
    input  logic [WIDTH-1:0] jcmpImm,
    input  logic [WIDTH-1:0] jcmpImmLS,
    output logic [WIDTH-1:0] pcCur,
    output logic             rasEmpty,
    output logic             rasFull,
    output logic             rasOverflow,
    output logic             rasUnderflow,
    output logic             misalign
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_next_raw;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_hit;
    logic             w_push;
    logic             w_pop;

    assign w_pc_inc = WIDTH'(pc_inc_wrap(PC_MAX_W'(r_pc), PC_MAX_W'(INC), WIDTH));
    assign w_push   = pcWrite & call;
    assign w_pop    = pcWrite & (pcSrc == PC_SRC_RET);

    always_comb begin
        w_next_raw = r_pc;
        case (pcSrc)
            PC_SRC_INC:     w_next_raw = w_pc_inc;
            PC_SRC_IMMPC:   w_next_raw = immPlusPC;
            PC_SRC_IMMADDR: w_next_raw = immAddr;
            PC_SRC_RA:      w_next_raw = ra;
            PC_SRC_MARY:    w_next_raw = mary;
            PC_SRC_PCMARY:  w_next_raw = pcPlusMary;
            PC_SRC_JCMP:    w_next_raw = jcmpImm;
            PC_SRC_JCMPLS:  w_next_raw = jcmpImmLS;
            PC_SRC_RET:     w_next_raw = w_ras_hit ? w_ras_top : ra;
            default:        w_next_raw = r_pc;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC - 1);

    logic w_load;
    logic w_misal;
    logic r_misalign;

    // Only real target loads are checked; sequential fetch and hold are exempt.
    assign w_load  = (pcSrc != PC_SRC_INC) && (pcSrc <= PC_SRC_RET);
    assign w_misal = w_load && ((w_next_raw & LOW_MASK) != '0);
    assign w_next  = w_load ? (w_next_raw & ~LOW_MASK) : w_next_raw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_misalign <= 1'b0;
        else
            r_misalign <= pcWrite & w_misal;
    end

    assign misalign = r_misalign;
`else
    assign w_next   = w_next_raw;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_pc <= RESET_VEC;
        else if (pcWrite)
            r_pc <= w_next;
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .pop_hit   (w_ras_hit),
        .top_data  (w_ras_top),
        .empty     (rasEmpty),
        .full      (rasFull),
        .overflow  (rasOverflow),
        .underflow (rasUnderflow)
    );

    assign pcCur = r_pc;

endmodule
